// File: rtl/relu_pkg.sv
// Shared definitions for activation blocks: default sample width, the signed
// sample type and the ReLU clamp used by the datapath and reference models.
package relu_pkg;

   localparam int DEFAULT_DATA_W = 16;

   typedef logic signed [DEFAULT_DATA_W-1:0] sample_t;

   // Negative samples (sign bit set) clamp to zero; everything else passes as-is.
   function automatic sample_t relu_f(input sample_t sample);
      return sample[DEFAULT_DATA_W-1] ? '0 : sample;
   endfunction

endpackage

// File: rtl/pipelined_relu_if.sv
// Sample stream bundle for the ReLU stage: master drives samples in, slave returns results.
interface pipelined_relu_if #(
   parameter int DATA_W = 16
) ();

   logic signed [DATA_W-1:0] data_in;
   logic signed [DATA_W-1:0] data_out;

   modport master (output data_in, input data_out);
   modport slave  (input data_in, output data_out);

endinterface

// File: rtl/relu_delay_stage.sv
// One DATA_W-wide pipeline register with synchronous active-low clear.
module relu_delay_stage #(
   parameter int DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] d,
   output logic signed [DATA_W-1:0] q
);

   logic signed [DATA_W-1:0] data_d;
   logic signed [DATA_W-1:0] data_q;

   always_comb begin
      data_d = d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule

// File: rtl/pipelined_relu.sv
// Registered ReLU: combinational clamp in front of a LATENCY-deep register chain;
// data_out always comes straight from the last register.
module pipelined_relu
   import relu_pkg::*;
#(
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int LATENCY = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] data_in,
   output logic signed [DATA_W-1:0] data_out
);

   if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $error("pipelined_relu: LATENCY must be in 1..8");
   end

   logic signed [DATA_W-1:0] relu_d;
   logic signed [DATA_W-1:0] chain [LATENCY+1];

   // The shared function is fixed at the default width; other widths clamp inline.
   if (DATA_W == DEFAULT_DATA_W) begin : g_pkg_relu
      always_comb begin
         relu_d = relu_f(data_in);
      end
   end else begin : g_local_relu
      always_comb begin
         relu_d = data_in[DATA_W-1] ? '0 : data_in;
      end
   end

   assign chain[0] = relu_d;

   for (genvar i = 0; i < LATENCY; i++) begin : g_stage
      relu_delay_stage #(
         .DATA_W(DATA_W)
      ) u_stage (
         .clk  (clk),
         .rst_n(rst_n),
         .d    (chain[i]),
         .q    (chain[i+1])
      );
   end

   assign data_out = chain[LATENCY];

endmodule

// File: tb/tb_pipelined_relu.sv
// Directed bench for pipelined_relu at LATENCY 1 and 3, checked against an edge-history model.
module tb_pipelined_relu;

   localparam int W        = 16;
   localparam int MAX_EDGE = 64;

   logic clk = 1'b0;
   logic rst_n;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   logic [W-1:0] hist_in  [MAX_EDGE];
   logic         hist_rst [MAX_EDGE];
   int           edge_cnt = 0;

   pipelined_relu_if #(.DATA_W(W)) bus1 ();
   pipelined_relu_if #(.DATA_W(W)) bus3 ();

   pipelined_relu #(.DATA_W(W), .LATENCY(1)) dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_in (bus1.data_in),
      .data_out(bus1.data_out)
   );

   pipelined_relu #(.DATA_W(W), .LATENCY(3)) dut3 (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_in (bus3.data_in),
      .data_out(bus3.data_out)
   );

   always #5 clk = ~clk;

   // Record what each rising edge saw; both DUTs share one input stream.
   always @(posedge clk) begin
      if (edge_cnt < MAX_EDGE) begin
         hist_in[edge_cnt]  = bus1.data_in;
         hist_rst[edge_cnt] = rst_n;
      end
      edge_cnt = edge_cnt + 1;
   end

   // Output after edge n: zero if any reset edge lies in the window of the last
   // lat edges (or the window reaches before time began), else the clamped sample
   // captured lat-1 edges earlier.
   function automatic logic [W-1:0] model_out(input int lat, input int n);
      logic [W-1:0] v;
      for (int k = n - lat + 1; k <= n; k++) begin
         if (k < 0) return '0;
         if (!hist_rst[k]) return '0;
      end
      v = hist_in[n - lat + 1];
      if ($signed(v) < 0) return '0;
      return v;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
      end
   endtask

   // Model compare on every falling edge once at least one rising edge has occurred.
   always @(negedge clk) begin
      if (edge_cnt > 0 && edge_cnt <= MAX_EDGE) begin
         check($sformatf("model_lat1_e%0d", edge_cnt - 1), bus1.data_out, model_out(1, edge_cnt - 1));
         check($sformatf("model_lat3_e%0d", edge_cnt - 1), bus3.data_out, model_out(3, edge_cnt - 1));
      end
   end

   task automatic step(input logic r, input logic [W-1:0] din);
      rst_n         = r;
      bus1.data_in  = din;
      bus3.data_in  = din;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n        = 1'b0;
      bus1.data_in = '0;
      bus3.data_in = '0;

      // Reset held for two edges with a nonzero input.
      step(1'b0, 16'h1234);
      check("reset_e0_lat1", bus1.data_out, 16'h0000);
      check("reset_e0_lat3", bus3.data_out, 16'h0000);
      step(1'b0, 16'h1234);
      check("reset_e1_lat1", bus1.data_out, 16'h0000);

      // Release: positive pass and negative clamps.
      step(1'b1, 16'h0010);
      check("pos_pass", bus1.data_out, 16'h0010);
      check("lat3_fill0", bus3.data_out, 16'h0000);
      step(1'b1, 16'hFFF0);
      check("neg_clamp", bus1.data_out, 16'h0000);
      check("lat3_fill1", bus3.data_out, 16'h0000);
      step(1'b1, 16'h8000);
      check("most_neg", bus1.data_out, 16'h0000);
      check("lat3_first", bus3.data_out, 16'h0010);

      // Back-to-back boundary values.
      step(1'b1, 16'h7FFF);
      check("most_pos", bus1.data_out, 16'h7FFF);
      step(1'b1, 16'h0000);
      check("zero", bus1.data_out, 16'h0000);
      step(1'b1, 16'h0001);
      check("one", bus1.data_out, 16'h0001);
      check("lat3_most_pos", bus3.data_out, 16'h7FFF);
      step(1'b1, 16'hFFFF);
      check("minus_one", bus1.data_out, 16'h0000);

      // Mid-stream reset discards in-flight samples.
      step(1'b1, 16'h0100);
      check("mid_0100", bus1.data_out, 16'h0100);
      step(1'b1, 16'h0200);
      check("mid_0200", bus1.data_out, 16'h0200);
      step(1'b0, 16'h0300);
      check("mid_reset_lat1", bus1.data_out, 16'h0000);
      check("mid_reset_lat3", bus3.data_out, 16'h0000);
      step(1'b1, 16'h0400);
      check("mid_release", bus1.data_out, 16'h0400);
      check("mid_release_lat3", bus3.data_out, 16'h0000);
      step(1'b1, 16'h0000);
      check("mid_flush_lat3", bus3.data_out, 16'h0000);

      // Deep pipeline after a fresh reset.
      step(1'b0, 16'h7777);
      check("deep_reset", bus3.data_out, 16'h0000);
      step(1'b1, 16'h0005);
      check("deep_e1", bus3.data_out, 16'h0000);
      check("deep_e1_lat1", bus1.data_out, 16'h0005);
      step(1'b1, 16'hFFFB);
      check("deep_e2", bus3.data_out, 16'h0000);
      step(1'b1, 16'h0003);
      check("deep_e3", bus3.data_out, 16'h0005);
      step(1'b1, 16'h0000);
      check("deep_e4", bus3.data_out, 16'h0000);
      step(1'b1, 16'h0000);
      check("deep_e5", bus3.data_out, 16'h0003);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
